// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid checker: FSM states, status word layout,
// host address map and the status packing helper.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdId = 3'd1,
    StRdTs = 3'd2,
    StEval = 3'd3,
    StWait = 3'd4
  } state_e;

  localparam int unsigned StatIdOkBit   = 0;
  localparam int unsigned StatIdFailBit = 1;
  localparam int unsigned StatBusyBit   = 2;
  localparam int unsigned StatRetryLsb  = 8;
  localparam int unsigned RetryW        = 4;
  localparam int unsigned WaitCntW      = 24;

  localparam logic [1:0] AddrId     = 2'd0;
  localparam logic [1:0] AddrTs     = 2'd1;
  localparam logic [1:0] AddrStatus = 2'd2;
  localparam logic [1:0] AddrRsvd   = 2'd3;

  function automatic logic [31:0] pack_status(input logic              ok,
                                              input logic              fail,
                                              input logic              busy,
                                              input logic [RetryW-1:0] retry);
    logic [31:0] s;
    s                           = '0;
    s[StatIdOkBit]              = ok;
    s[StatIdFailBit]            = fail;
    s[StatBusyBit]              = busy;
    s[StatRetryLsb +: RetryW]   = retry;
    return s;
  endfunction

endpackage

// File: rtl/sysid_rr_arb.sv
// Two-requester round-robin arbiter for the shared sysid port. Priority only
// flips when both sides request in the same cycle; the checker wins first.
module sysid_rr_arb (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_chk_i,
  input  logic req_host_i,
  output logic gnt_chk_o,
  output logic gnt_host_o
);

  // ptr_q = 1 means the host holds priority on the next conflict.
  logic ptr_q, ptr_d;
  logic conflict;

  always_comb begin
    conflict   = req_chk_i & req_host_i;
    gnt_chk_o  = req_chk_i & (~req_host_i | ~ptr_q);
    gnt_host_o = req_host_i & (~req_chk_i | ptr_q);
    ptr_d      = conflict ? ~ptr_q : ptr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sysid_check_ctrl.sv
// Periodically reads the sysid slave (ID and timestamp), compares against expected
// values with retry/sticky-fail tracking, and shares the sysid port with a host reader.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1543892682,
  parameter int unsigned RECHECK_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  host_address,
  input  logic        host_read,
  output logic        host_waitrequest,
  output logic [31:0] host_readdata,
  output logic        host_readdatavalid,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  output logic        id_ok,
  output logic        id_fail,
  output logic        check_busy
);

  localparam logic [WaitCntW-1:0] RecheckLoad = WaitCntW'(RECHECK_CYCLES);
  localparam logic [WaitCntW-1:0] WaitOne     = WaitCntW'(1);
  localparam logic [RetryW-1:0]   MaxRetry    = RetryW'(MAX_RETRIES);
  localparam logic [RetryW-1:0]   RetryOne    = RetryW'(1);

  state_e              state_q, state_d;
  logic                id_ok_q, id_ok_d;
  logic                id_fail_q, id_fail_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]         id_word_q, id_word_d;
  logic [31:0]         ts_word_q, ts_word_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  logic              chk_req, host_req;
  logic              gnt_chk, gnt_host;
  logic              host_accept;
  logic              words_match;
  logic [RetryW-1:0] retry_inc;
  logic [31:0]       status_word;

  sysid_rr_arb u_arb (
    .clk_i      (clock),
    .rst_i      (reset),
    .req_chk_i  (chk_req),
    .req_host_i (host_req),
    .gnt_chk_o  (gnt_chk),
    .gnt_host_o (gnt_host)
  );

  // Port sharing: only ID/timestamp host reads compete for the sysid slave.
  always_comb begin
    check_busy       = (state_q == StRdId) || (state_q == StRdTs);
    chk_req          = check_busy;
    host_req         = host_read & ~host_address[1];
    host_waitrequest = host_req & ~gnt_host;
    host_accept      = host_read & ~host_waitrequest;
    if (gnt_host) begin
      sid_address = host_address[0];
    end else begin
      sid_address = gnt_chk & (state_q == StRdTs);
    end
  end

  always_comb begin
    words_match = (id_word_q == EXPECTED_ID) && (ts_word_q == EXPECTED_TS);
    retry_inc   = (retry_q >= MaxRetry) ? MaxRetry : (retry_q + RetryOne);
    status_word = pack_status(id_ok_q, id_fail_q, check_busy, retry_q);
  end

  // Checker FSM next state.
  always_comb begin
    state_d    = state_q;
    id_ok_d    = id_ok_q;
    id_fail_d  = id_fail_q;
    retry_d    = retry_q;
    wait_cnt_d = wait_cnt_q;
    id_word_d  = id_word_q;
    ts_word_d  = ts_word_q;

    unique case (state_q)
      StIdle: begin
        state_d = StRdId;
      end
      StRdId: begin
        if (gnt_chk) begin
          id_word_d = sid_readdata;
          state_d   = StRdTs;
        end
      end
      StRdTs: begin
        if (gnt_chk) begin
          ts_word_d = sid_readdata;
          state_d   = StEval;
        end
      end
      StEval: begin
        if (words_match) begin
          id_ok_d    = 1'b1;
          retry_d    = '0;
          wait_cnt_d = RecheckLoad;
          state_d    = StWait;
        end else begin
          id_ok_d = 1'b0;
          retry_d = retry_inc;
          if (retry_inc == MaxRetry) begin
            id_fail_d  = 1'b1;
            wait_cnt_d = RecheckLoad;
            state_d    = StWait;
          end else begin
            state_d = StRdId;
          end
        end
      end
      StWait: begin
        // Counter was loaded on entry, so a load of N spends exactly N cycles here.
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - WaitOne;
        end
        if (wait_cnt_q <= WaitOne) begin
          state_d = StRdId;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Host read data path: one-cycle registered response.
  always_comb begin
    rvalid_d = host_accept;
    rdata_d  = rdata_q;
    if (host_accept) begin
      case (host_address)
        AddrId, AddrTs: rdata_d = sid_readdata;
        AddrStatus:     rdata_d = status_word;
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      id_ok_q    <= 1'b0;
      id_fail_q  <= 1'b0;
      retry_q    <= '0;
      wait_cnt_q <= '0;
      id_word_q  <= '0;
      ts_word_q  <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_ok_q    <= id_ok_d;
      id_fail_q  <= id_fail_d;
      retry_q    <= retry_d;
      wait_cnt_q <= wait_cnt_d;
      id_word_q  <= id_word_d;
      ts_word_q  <= ts_word_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign id_ok              = id_ok_q;
  assign id_fail            = id_fail_q;
  assign host_readdata      = rdata_q;
  assign host_readdatavalid = rvalid_q;

endmodule
